// File: rtl/carry_ctrl_pkg.sv
// Shared definitions for the carry-resolution controller: FSM state
// encoding, the bytes emitted for a pending run, and small helpers.
package carry_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESOLVE,
    ST_EMIT_H,
    ST_EMIT_RUN,
    ST_FLUSH_H,
    ST_FLUSH_RUN,
    ST_DONE
  } state_t;

  // A pending run of 0xFF bytes becomes 0x00 bytes once a carry ripples through it.
  localparam logic [7:0] RUN_BYTE_NO_CARRY = 8'hFF;
  localparam logic [7:0] RUN_BYTE_CARRY    = 8'h00;

  function automatic logic [7:0] runByte(input logic carry);
    return carry ? RUN_BYTE_CARRY : RUN_BYTE_NO_CARRY;
  endfunction

  // Bits [15:9] of an input word carry no meaning and must be zero.
  function automatic logic badUpper(input logic [15:0] word);
    return |word[15:9];
  endfunction

endpackage

// File: rtl/carry_run_counter.sv
// Counter for the number of 0xFF bytes held back behind the held byte.
// Increments saturate at all-ones and report the overflow attempt.
module carry_run_counter
  import carry_ctrl_pkg::*;
#(
  parameter int RUN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [RUN_W-1:0] o_count,
  output logic             o_zero,
  output logic             o_satHit
);

  logic [RUN_W-1:0] r_count;
  logic             w_max;

  assign w_max    = &r_count;
  assign o_count  = r_count;
  assign o_zero   = (r_count == '0);
  assign o_satHit = i_inc & w_max;

  // Clear has priority; increment holds at all-ones, decrement holds at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && !w_max) begin
      r_count <= r_count + RUN_W'(1);
    end else if (i_dec && !o_zero) begin
      r_count <= r_count - RUN_W'(1);
    end
  end

endmodule

// File: rtl/carry_ctrl.sv
// Carry-resolution controller: takes stage-3 words (new byte plus carry into
// earlier bytes), holds back the latest byte and any run of 0xFF bytes until
// the carry into them is known, then emits the resolved bytes in order.
module carry_ctrl
  import carry_ctrl_pkg::*;
#(
  parameter int RUN_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_flag,
  input  logic        in_final,
  input  logic [15:0] in_word_1,
  input  logic [15:0] in_word_2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_byte,
  output logic        out_done,
  output logic        out_err
);

  state_t           r_state;
  logic [7:0]       r_held;
  logic             r_holdValid;
  logic             r_carry;
  logic [7:0]       r_staged;
  logic             r_wordIdx;
  logic             r_twoWords;
  logic             r_final;
  logic [8:0]       r_word1;
  logic [8:0]       r_word2;
  logic             r_outValid;
  logic [7:0]       r_outByte;
  logic             r_outDone;
  logic             r_outErr;

  logic [8:0]       w_curWord;
  logic             w_curCarry;
  logic [7:0]       w_curByte;
  logic             w_badIn;
  logic             w_extendRun;
  logic             w_runConsume;
  logic             w_lastRunByte;
  logic             w_cntInc;
  logic             w_cntDec;
  logic             w_cntClear;
  logic [RUN_W-1:0] w_cnt;
  logic             w_cntZero;
  logic             w_cntSatHit;
  state_t           w_contState;

  assign w_curWord  = r_wordIdx ? r_word2 : r_word1;
  assign w_curCarry = w_curWord[8];
  assign w_curByte  = w_curWord[7:0];

  assign w_badIn = ((in_flag != 2'b00) && badUpper(in_word_1)) ||
                   ((in_flag == 2'b11) && badUpper(in_word_2));

  assign w_extendRun   = (r_state == ST_RESOLVE) && r_holdValid &&
                         !w_curCarry && (w_curByte == 8'hFF);
  assign w_runConsume  = ((r_state == ST_EMIT_RUN) || (r_state == ST_FLUSH_RUN)) &&
                         r_outValid && out_ready;
  assign w_lastRunByte = (w_cnt == RUN_W'(1));

  assign w_cntInc   = w_extendRun;
  assign w_cntDec   = w_runConsume;
  assign w_cntClear = (r_state == ST_DONE);

  carry_run_counter #(.RUN_W(RUN_W)) u_runCounter (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_cntClear),
    .i_inc    (w_cntInc),
    .i_dec    (w_cntDec),
    .o_count  (w_cnt),
    .o_zero   (w_cntZero),
    .o_satHit (w_cntSatHit)
  );

  // Where to go once the current word is fully handled: second word, flush, or back to idle.
  always_comb begin
    w_contState = ST_IDLE;
    if (!r_wordIdx && r_twoWords) begin
      w_contState = ST_RESOLVE;
    end else if (r_final) begin
      w_contState = ST_FLUSH_H;
    end
  end

  assign in_ready  = reset && (r_state == ST_IDLE);
  assign out_valid = r_outValid;
  assign out_byte  = r_outByte;
  assign out_done  = r_outDone;
  assign out_err   = r_outErr;

  // Controller FSM; each emitting state loads its output byte, then waits for out_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_held      <= 8'h00;
      r_holdValid <= 1'b0;
      r_carry     <= 1'b0;
      r_staged    <= 8'h00;
      r_wordIdx   <= 1'b0;
      r_twoWords  <= 1'b0;
      r_final     <= 1'b0;
      r_word1     <= 9'h000;
      r_word2     <= 9'h000;
      r_outValid  <= 1'b0;
      r_outByte   <= 8'h00;
      r_outDone   <= 1'b0;
      r_outErr    <= 1'b0;
    end else begin
      if (w_cntSatHit) begin
        r_outErr <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_word1    <= in_word_1[8:0];
            r_word2    <= in_word_2[8:0];
            r_twoWords <= (in_flag == 2'b11);
            r_final    <= in_final;
            r_wordIdx  <= 1'b0;
            if (w_badIn) begin
              r_outErr <= 1'b1;
            end
            if (in_flag != 2'b00) begin
              r_state <= ST_RESOLVE;
            end else if (in_final) begin
              r_state <= ST_FLUSH_H;
            end
          end
        end
        ST_RESOLVE: begin
          if (!r_holdValid) begin
            r_held      <= w_curByte;
            r_holdValid <= 1'b1;
            if (w_curCarry) begin
              r_outErr <= 1'b1;
            end
            r_wordIdx <= 1'b1;
            r_state   <= w_contState;
          end else if (w_extendRun) begin
            r_wordIdx <= 1'b1;
            r_state   <= w_contState;
          end else begin
            r_carry  <= w_curCarry;
            r_staged <= w_curByte;
            r_state  <= ST_EMIT_H;
          end
        end
        ST_EMIT_H: begin
          if (!r_outValid) begin
            r_outValid <= 1'b1;
            r_outByte  <= r_held + {7'd0, r_carry};
            if ((r_held == 8'hFF) && r_carry) begin
              r_outErr <= 1'b1;
            end
          end else if (out_ready) begin
            r_outValid <= 1'b0;
            if (!w_cntZero) begin
              r_state <= ST_EMIT_RUN;
            end else begin
              r_held    <= r_staged;
              r_wordIdx <= 1'b1;
              r_state   <= w_contState;
            end
          end
        end
        ST_EMIT_RUN: begin
          if (!r_outValid) begin
            r_outValid <= 1'b1;
            r_outByte  <= runByte(r_carry);
          end else if (out_ready) begin
            r_outValid <= 1'b0;
            if (w_lastRunByte) begin
              r_held    <= r_staged;
              r_wordIdx <= 1'b1;
              r_state   <= w_contState;
            end
          end
        end
        ST_FLUSH_H: begin
          if (!r_outValid) begin
            if (r_holdValid) begin
              r_outValid <= 1'b1;
              r_outByte  <= r_held;
            end else if (w_cntZero) begin
              r_outDone <= 1'b1;
              r_state   <= ST_DONE;
            end else begin
              r_state <= ST_FLUSH_RUN;
            end
          end else if (out_ready) begin
            r_outValid <= 1'b0;
            if (w_cntZero) begin
              r_outDone <= 1'b1;
              r_state   <= ST_DONE;
            end else begin
              r_state <= ST_FLUSH_RUN;
            end
          end
        end
        ST_FLUSH_RUN: begin
          if (!r_outValid) begin
            r_outValid <= 1'b1;
            r_outByte  <= RUN_BYTE_NO_CARRY;
          end else if (out_ready) begin
            r_outValid <= 1'b0;
            if (w_lastRunByte) begin
              r_outDone <= 1'b1;
              r_state   <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_outDone   <= 1'b0;
          r_holdValid <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_carry_ctrl.sv
// Self-checking bench for carry_ctrl: directed frames plus random frames,
// compared against a digit-queue model of big-integer carry propagation.
module tb_carry_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_flag;
  logic        in_final;
  logic [15:0] in_word_1;
  logic [15:0] in_word_2;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_done;
  logic        out_err;

  carry_ctrl #(.RUN_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_flag   (in_flag),
    .in_final  (in_final),
    .in_word_1 (in_word_1),
    .in_word_2 (in_word_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_done  (out_done),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;

  logic [7:0] gotQ[$];
  logic [7:0] expQ[$];
  logic [7:0] pendQ[$];
  bit         expErr    = 1'b0;
  int         expDone   = 0;
  int         doneCount = 0;
  int         readyMode = 0;
  bit         stallPrev = 1'b0;
  logic [7:0] stallByte = 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Pending bytes form the low digits of a big integer; a carry adds one to it.
  function automatic void modelWord(input logic [15:0] w);
    logic       c;
    logic [7:0] s;
    int         i;
    c = w[8];
    s = w[7:0];
    if (w[15:9] != 7'd0) expErr = 1'b1;
    if (pendQ.size() == 0) begin
      if (c) expErr = 1'b1;
      pendQ.push_back(s);
      return;
    end
    if (c) begin
      i = pendQ.size() - 1;
      while (i > 0 && pendQ[i] == 8'hFF) begin
        pendQ[i] = 8'h00;
        i--;
      end
      if (i == 0 && pendQ[0] == 8'hFF) expErr = 1'b1;
      pendQ[i] = pendQ[i] + 8'd1;
    end
    if (!c && s == 8'hFF) begin
      pendQ.push_back(s);
    end else begin
      foreach (pendQ[k]) expQ.push_back(pendQ[k]);
      pendQ.delete();
      pendQ.push_back(s);
    end
  endfunction

  function automatic void modelResult(input logic [1:0] flag, input logic fin,
                                      input logic [15:0] w1, input logic [15:0] w2);
    if (flag != 2'b00) modelWord(w1);
    if (flag == 2'b11) modelWord(w2);
    if (fin) begin
      foreach (pendQ[k]) expQ.push_back(pendQ[k]);
      pendQ.delete();
      expDone++;
    end
  endfunction

  // Downstream ready pattern: always, alternating, random, or left to the stimulus.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      2: out_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // Collect consumed bytes, count done pulses, and check stalled bytes stay put.
  always @(negedge clk) begin
    if (!reset) begin
      stallPrev = 1'b0;
    end else begin
      if (stallPrev) begin
        checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("stall_byte", {24'd0, out_byte}, {24'd0, stallByte});
      end
      if (out_done) doneCount++;
      if (out_valid && out_ready) gotQ.push_back(out_byte);
      stallPrev = out_valid && !out_ready;
      stallByte = out_byte;
    end
  end

  task automatic applyStimulus(input logic [1:0] flag, input logic fin,
                               input logic [15:0] w1, input logic [15:0] w2);
    int cyc;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_flag   = flag;
    in_final  = fin;
    in_word_1 = w1;
    in_word_2 = w2;
    cyc = 0;
    @(negedge clk);
    while (!in_ready && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    modelResult(flag, fin, w1, w2);
  endtask

  task automatic checkFrame(input string tag);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while ((gotQ.size() < expQ.size() || doneCount < expDone || !in_ready) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (6) @(negedge clk);
    checkOutput({tag, "_count"}, gotQ.size(), expQ.size());
    for (int k = 0; k < expQ.size() && k < gotQ.size(); k++)
      checkOutput($sformatf("%s_byte%0d", tag, k), {24'd0, gotQ[k]}, {24'd0, expQ[k]});
    checkOutput({tag, "_done"}, doneCount, expDone);
    checkOutput({tag, "_err"}, {31'd0, out_err}, {31'd0, expErr});
    gotQ.delete();
    expQ.delete();
  endtask

  function automatic logic [15:0] randWord();
    logic [7:0] b;
    int         r;
    r = $urandom_range(0, 9);
    if (r < 3) b = 8'hFF;
    else if (r < 4) b = 8'h00;
    else b = 8'($urandom_range(0, 255));
    return {7'd0, ($urandom_range(0, 3) == 0), b};
  endfunction

  initial begin
    int cyc;
    int nRes;
    logic [1:0] fl;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_flag   = 2'b00;
    in_final  = 1'b0;
    in_word_1 = 16'h0000;
    in_word_2 = 16'h0000;
    out_ready = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_byte", {24'd0, out_byte}, 32'd0);
    checkOutput("rst_out_done", {31'd0, out_done}, 32'd0);
    checkOutput("rst_out_err", {31'd0, out_err}, 32'd0);
    #1 reset = 1'b1;

    // Two plain bytes.
    applyStimulus(2'b11, 1'b1, 16'h0012, 16'h0034);
    checkFrame("req037");

    // Carry ripples through a run of two 0xFF bytes.
    applyStimulus(2'b01, 1'b0, 16'h0012, 16'h0000);
    applyStimulus(2'b11, 1'b0, 16'h00FF, 16'h00FF);
    applyStimulus(2'b01, 1'b1, 16'h0100, 16'h0000);
    checkFrame("req038");

    // Run of one 0xFF released without a carry (flag 10 acts as 01).
    applyStimulus(2'b10, 1'b0, 16'h0012, 16'h0000);
    applyStimulus(2'b01, 1'b0, 16'h00FF, 16'h0000);
    applyStimulus(2'b01, 1'b1, 16'h0056, 16'h0000);
    checkFrame("req040");

    // Two-word result with downstream alternating ready.
    readyMode = 1;
    applyStimulus(2'b11, 1'b1, 16'h0020, 16'h0130);
    checkFrame("req041");
    readyMode = 0;

    // Carry into a held 0xFF wraps and flags an error, then flush.
    applyStimulus(2'b01, 1'b0, 16'h00FF, 16'h0000);
    applyStimulus(2'b01, 1'b0, 16'h0100, 16'h0000);
    checkFrame("req039");
    applyStimulus(2'b00, 1'b1, 16'h0000, 16'h0000);
    checkFrame("req039_flush");

    // Reset while emitting a three-byte run.
    readyMode = 3;
    out_ready = 1'b0;
    applyStimulus(2'b01, 1'b0, 16'h0012, 16'h0000);
    applyStimulus(2'b11, 1'b0, 16'h00FF, 16'h00FF);
    applyStimulus(2'b01, 1'b0, 16'h00FF, 16'h0000);
    applyStimulus(2'b01, 1'b0, 16'h0034, 16'h0000);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("rst_emit_h", {24'd0, out_byte}, 32'h12);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("rst_emit_run", {24'd0, out_byte}, 32'hFF);
    #1 reset = 1'b0;
    #1;
    checkOutput("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_mid_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_mid_err", {31'd0, out_err}, 32'd0);
    repeat (2) @(posedge clk);
    gotQ.delete();
    expQ.delete();
    pendQ.delete();
    expErr = 1'b0;
    readyMode = 0;
    #1 reset = 1'b1;
    applyStimulus(2'b01, 1'b1, 16'h0056, 16'h0000);
    checkFrame("req042");

    // Nonzero upper bits are flagged but the low byte still flows.
    applyStimulus(2'b01, 1'b1, 16'h0212, 16'h0000);
    checkFrame("upper_bits");

    // Random frames against the model.
    for (int f = 0; f < 25; f++) begin
      readyMode = $urandom_range(0, 2);
      nRes = $urandom_range(1, 5);
      for (int r = 0; r < nRes; r++) begin
        fl = 2'($urandom_range(0, 3));
        applyStimulus(fl, (r == nRes - 1), randWord(), randWord());
      end
      checkFrame($sformatf("rand%0d", f));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
